// File: rtl/mult4_pkg.sv
// Shared types for the sequential shift-and-add multiplier.
// Holds the controller state encoding and the adder width.
package mult4_pkg;

    localparam int MULT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/four_bit_FA.sv
// Four-bit ripple-carry adder shared by the multiplier datapath.
// Produces a 4-bit sum plus carry-out.
module four_bit_FA
    import mult4_pkg::*;
(
    input  logic [MULT_W-1:0] a_i,
    input  logic [MULT_W-1:0] b_i,
    input  logic              cin_i,
    output logic [MULT_W-1:0] sum_o,
    output logic              cout_o
);

    logic [MULT_W:0] c;

    assign c[0] = cin_i;

    for (genvar i = 0; i < MULT_W; i++) begin : g_fa
        logic p;
        assign p        = a_i[i] ^ b_i[i];
        assign sum_o[i] = p ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & p);
    end

    assign cout_o = c[MULT_W];

endmodule

// File: rtl/mult4_seq_ctrl.sv
// Shift-and-add unsigned multiplier controller with valid/ready on both sides.
// Optional MULT4_ZERO_SKIP_EN: zero operands bypass the RUN iterations.
module mult4_seq_ctrl
    import mult4_pkg::*;
#(
    parameter int WIDTH = MULT_W,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic [WIDTH-1:0]   ar_q, ar_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_s;
    logic               add_co;
    logic [WIDTH:0]     sum;

    // Only the multiplicand or zero is ever added, selected by the multiplier LSB.
    assign add_b = mq_q[0] ? ar_q : '0;

    four_bit_FA u_add (
        .a_i    (acc_q),
        .b_i    (add_b),
        .cin_i  (1'b0),
        .sum_o  (add_s),
        .cout_o (add_co)
    );

    assign sum = {add_co, add_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            ar_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            ar_q    <= ar_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        ar_d      = ar_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        product   = '0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    ar_d    = a;
                    mq_d    = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef MULT4_ZERO_SKIP_EN
                    if ((a == '0) || (b == '0)) begin
                        mq_d    = '0;
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                busy = 1'b1;
                // Shift the sum right across acc:mq so the carry is kept.
                acc_d = sum[WIDTH:1];
                mq_d  = {sum[0], mq_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                product   = {acc_q, mq_q};
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// Directed self-checking bench for mult4_seq_ctrl.
// Honours MULT4_ZERO_SKIP_EN when computing expected latency.
module tb_mult4_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] product;
    logic       busy;

    int checks;
    int errors;

    mult4_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic [3:0] av, input logic [3:0] bv,
                         input logic [7:0] exp, input int hold,
                         input bit inject);
        int n;
        int nb;
        int lat;
        lat = 4;
`ifdef MULT4_ZERO_SKIP_EN
        if (av == 4'd0 || bv == 4'd0) lat = 0;
`endif
        chk("in_ready_idle", 32'(in_ready), 1);
        a         = av;
        b         = bv;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        if (inject) begin
            a = 4'd2;
            b = 4'd2;
        end else begin
            in_valid = 1'b0;
        end
        n  = 0;
        nb = 0;
        while (!out_valid && n < 20) begin
            if (busy) nb++;
            chk("in_ready_run", 32'(in_ready), 0);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (n >= 20) chk("timeout", 32'(out_valid), 1);
        chk("latency", n, lat);
        chk("busy_cycles", nb, lat);
        chk("product", 32'(product), 32'(exp));
        chk("busy_done", 32'(busy), 0);
        chk("in_ready_done", 32'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_product", 32'(product), 32'(exp));
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_product", 32'(product), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(4'd15, 4'd15, 8'hE1, 0, 1'b0);
        do_op(4'd7,  4'd3,  8'd21, 0, 1'b1);
        do_op(4'd1,  4'd8,  8'd8,  0, 1'b0);
        do_op(4'd9,  4'd6,  8'd54, 10, 1'b0);

        chk("pre_rst_in_ready", 32'(in_ready), 1);
        a        = 4'd15;
        b        = 4'd15;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("run2_busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_product", 32'(product), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        do_op(4'd5,  4'd5,  8'd25, 0, 1'b0);
        do_op(4'd0,  4'd13, 8'd0,  0, 1'b0);
        do_op(4'd13, 4'd0,  8'd0,  3, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
